rc4_mem_handler: RTL and testbench
==================================

// Module: rc4_mem_handler
// PURPOSE
//  Arbitrates the three RC4 memories between the init, shuffle (KSA) and decrypt (PRGA) engines.
//  Routes the active engine's address, data and write enable to one of three memories:
//    - working S-RAM (256x8)
//    - decrypted-message RAM (32x8)
//    - encrypted-message ROM (32x8)
//  Returns read data to the engines. Sits between the top-level controller/engines and the memory macros.
// PARAMETERS
//  none (widths fixed: S address 8b, message addresses 5b, data 8b)
// PORTS
//  clk                  in   1  system clock; single clock domain
//  reset_n              in   1  synchronous, active-low reset
//  start_init           in   1  init engine owns the memories
//  start_shuffle        in   1  shuffle engine owns the memories
//  start_decrypt        in   1  decrypt engine owns the memories
//  data_init/_shuffle/_decrypt       in  8 each  write data from each engine
//  wren_init/_shuffle/_decrypt       in  1 each  write enable from each engine
//  address_init/_shuffle/_decrypt    in  8 each  address from each engine
//  mem_sel_init/_shuffle/_decrypt    in  2 each  target memory: 0 none, 1 S-RAM, 2 decrypted RAM, 3 encrypted ROM
//  output_data_shuffle  out  8  read data to shuffle engine
//  output_data_decrypt  out  8  read data to decrypt engine
//  q                    in   8  S-RAM read data
//  wren, address, data  out  1/8/8  S-RAM write enable, address, write data
//  wren_d, data_d, address_d  out  1/8/5  decrypted RAM write enable, write data, address
//  q_m                  in   8  encrypted ROM read data
//  address_m            out  5  encrypted ROM address
//  conflict             out  1  sticky: more than one start_* seen high
// BEHAVIOUR
//  Owner selection (combinational, fixed priority): init > shuffle > decrypt; no start high => no owner.
//  Owner's sel/addr/data/wren are the "active" set.
//  Routing (combinational, same cycle):
//    - sel=1: address=addr, data=data, wren=wren.
//    - sel=2: address_d=addr[4:0], data_d=data, wren_d=wren.
//    - sel=3: address_m=addr[4:0]; ROM writes are ignored.
//  Non-selected memory ports drive address 0, data 0, wren 0. No owner or sel=0 => all outputs 0, all wren 0.
//  A write is never issued to more than one memory in the same cycle.
//  Read path:
//    - Memories have 1-cycle read latency. A registered copy of the decrypt engine's select
//      (rd_sel_q, 2b) is captured each clk, only while decrypt is the owner, else 0.
//    - output_data_decrypt = q if rd_sel_q==1, q_m if rd_sel_q==3, else 8'h00.
//    - output_data_shuffle = q, unconditional pass-through.
//  conflict: set on any clk edge where two or more start_* are high; held until reset.
//  Reset (reset_n low at clk edge): rd_sel_q=0, conflict=0. Combinational outputs follow inputs during reset.
//  Mid-operation ownership change: takes effect the same cycle; rd_sel_q drops to 0 the next edge.
//  Address truncation: message addresses use addr[4:0]; addr 255 -> 31.
// TESTING
//  1. reset, then start_init=1, mem_sel_init=1, address_init=255, wren_init=1, data_init=8'hAB
//       -> address=255, wren=1, data=AB; wren_d=0, address_d=0, address_m=0.
//  2. start_shuffle=1, mem_sel_shuffle=1, address_shuffle=255, wren_shuffle=1, then 0
//       -> wren follows 1 then 0; q=1 gives output_data_shuffle=1.
//  3. start_decrypt=1, mem_sel_decrypt=1/2/3, address_decrypt=10, wren_decrypt=1; q=1, q_m=2:
//       - sel 1 -> S write at 10.
//       - sel 2 -> address_d=10, wren_d=1, wren=0.
//       - sel 3 -> address_m=10, no wren.
//       - output_data_decrypt: 1 the cycle after sel=1, 2 the cycle after sel=3.
//  4. all start_* low -> every wren 0, addresses 0, output_data_decrypt 0 next cycle.
//  5. start_init and start_decrypt both high -> init routed; conflict=1 next edge, held until reset_n=0.
//  6. assert reset_n=0 mid-decrypt -> conflict=0, rd_sel_q=0, output_data_decrypt=0 after the edge.

Source files
------------

// File: rtl/rc4_mem_handler.sv
// Routes the owning RC4 engine (init > shuffle > decrypt) to the S-RAM, decrypted RAM or encrypted ROM.
// Routing is combinational; decrypt read data returns one cycle later. There is no backpressure.
module rc4_mem_handler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_init,
  input  logic       start_shuffle,
  input  logic       start_decrypt,
  input  logic [7:0] data_init,
  input  logic [7:0] data_shuffle,
  input  logic [7:0] data_decrypt,
  input  logic       wren_init,
  input  logic       wren_shuffle,
  input  logic       wren_decrypt,
  input  logic [7:0] address_init,
  input  logic [7:0] address_shuffle,
  input  logic [7:0] address_decrypt,
  input  logic [1:0] mem_sel_init,
  input  logic [1:0] mem_sel_shuffle,
  input  logic [1:0] mem_sel_decrypt,
  output logic [7:0] output_data_shuffle,
  output logic [7:0] output_data_decrypt,
  input  logic [7:0] q,
  output logic       wren,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic       wren_d,
  output logic [7:0] data_d,
  output logic [4:0] address_d,
  input  logic [7:0] q_m,
  output logic [4:0] address_m,
  output logic       conflict
);

  logic [1:0] act_sel;
  logic [7:0] act_addr;
  logic [7:0] act_data;
  logic       act_wren;
  logic       dec_owner;
  logic       multi_start;
  logic [1:0] rd_sel_q;

  always_comb begin
    act_sel   = 2'd0;
    act_addr  = 8'd0;
    act_data  = 8'd0;
    act_wren  = 1'b0;
    dec_owner = 1'b0;
    if (start_init) begin
      act_sel  = mem_sel_init;
      act_addr = address_init;
      act_data = data_init;
      act_wren = wren_init;
    end else if (start_shuffle) begin
      act_sel  = mem_sel_shuffle;
      act_addr = address_shuffle;
      act_data = data_shuffle;
      act_wren = wren_shuffle;
    end else if (start_decrypt) begin
      act_sel   = mem_sel_decrypt;
      act_addr  = address_decrypt;
      act_data  = data_decrypt;
      act_wren  = wren_decrypt;
      dec_owner = 1'b1;
    end
  end

  // Only one memory port is ever driven, so a write can never reach two memories.
  always_comb begin
    address   = 8'd0;
    data      = 8'd0;
    wren      = 1'b0;
    address_d = 5'd0;
    data_d    = 8'd0;
    wren_d    = 1'b0;
    address_m = 5'd0;
    case (act_sel)
      2'd1: begin
        address = act_addr;
        data    = act_data;
        wren    = act_wren;
      end
      2'd2: begin
        address_d = act_addr[4:0];
        data_d    = act_data;
        wren_d    = act_wren;
      end
      2'd3: address_m = act_addr[4:0];
      default: ;
    endcase
  end

  assign multi_start = (start_init & start_shuffle) |
                       (start_init & start_decrypt) |
                       (start_shuffle & start_decrypt);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_sel_q <= 2'd0;
      conflict <= 1'b0;
    end else begin
      rd_sel_q <= dec_owner ? mem_sel_decrypt : 2'd0;
      conflict <= conflict | multi_start;
    end
  end

  // rd_sel_q lines up with the memories' one-cycle read latency.
  always_comb begin
    case (rd_sel_q)
      2'd1:    output_data_decrypt = q;
      2'd3:    output_data_decrypt = q_m;
      default: output_data_decrypt = 8'h00;
    endcase
  end

  assign output_data_shuffle = q;

endmodule

// File: tb/tb_rc4_mem_handler.sv
// Directed bench for rc4_mem_handler: routing checks plus a queue-based scoreboard for decrypt read data.
module tb_rc4_mem_handler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_init, start_shuffle, start_decrypt;
  logic [7:0] data_init, data_shuffle, data_decrypt;
  logic       wren_init, wren_shuffle, wren_decrypt;
  logic [7:0] address_init, address_shuffle, address_decrypt;
  logic [1:0] mem_sel_init, mem_sel_shuffle, mem_sel_decrypt;
  logic [7:0] output_data_shuffle, output_data_decrypt;
  logic [7:0] q, q_m;
  logic       wren, wren_d;
  logic [7:0] address, data, data_d;
  logic [4:0] address_d, address_m;
  logic       conflict;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  rc4_mem_handler dut (
    .clk(clk), .reset_n(reset_n),
    .start_init(start_init), .start_shuffle(start_shuffle), .start_decrypt(start_decrypt),
    .data_init(data_init), .data_shuffle(data_shuffle), .data_decrypt(data_decrypt),
    .wren_init(wren_init), .wren_shuffle(wren_shuffle), .wren_decrypt(wren_decrypt),
    .address_init(address_init), .address_shuffle(address_shuffle), .address_decrypt(address_decrypt),
    .mem_sel_init(mem_sel_init), .mem_sel_shuffle(mem_sel_shuffle), .mem_sel_decrypt(mem_sel_decrypt),
    .output_data_shuffle(output_data_shuffle), .output_data_decrypt(output_data_decrypt),
    .q(q), .wren(wren), .address(address), .data(data),
    .wren_d(wren_d), .data_d(data_d), .address_d(address_d),
    .q_m(q_m), .address_m(address_m), .conflict(conflict)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected decrypt read data for the inputs present at the coming edge.
  function automatic logic [7:0] model_rd();
    if (!reset_n || start_init || start_shuffle || !start_decrypt) return 8'h00;
    if (mem_sel_decrypt == 2'd1) return q;
    if (mem_sel_decrypt == 2'd3) return q_m;
    return 8'h00;
  endfunction

  task automatic tick();
    sb.push_back(model_rd());
    @(posedge clk);
    #1;
    n_checks++;
    assert (sb.size() != 0 && output_data_decrypt === sb[0]) n_pass++;
    else $error("FAIL rd_decrypt: observed %0h expected %0h", output_data_decrypt,
                (sb.size() != 0) ? sb[0] : 8'hxx);
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic chk_idle_ports(input string tag);
    chk({tag, "_wren"}, {7'd0, wren}, 8'd0);
    chk({tag, "_wren_d"}, {7'd0, wren_d}, 8'd0);
    chk({tag, "_address"}, address, 8'd0);
    chk({tag, "_address_d"}, {3'd0, address_d}, 8'd0);
    chk({tag, "_address_m"}, {3'd0, address_m}, 8'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    {start_init, start_shuffle, start_decrypt} = 3'b000;
    {data_init, data_shuffle, data_decrypt} = '0;
    {wren_init, wren_shuffle, wren_decrypt} = 3'b000;
    {address_init, address_shuffle, address_decrypt} = '0;
    {mem_sel_init, mem_sel_shuffle, mem_sel_decrypt} = '0;
    q = 8'h01;
    q_m = 8'h02;
    tick();
    tick();
    chk("reset_conflict", {7'd0, conflict}, 8'd0);
    chk_idle_ports("reset");
    reset_n = 1'b1;

    // Init writes S-RAM at the top address, then the decrypted RAM (truncated address).
    start_init = 1'b1; mem_sel_init = 2'd1; address_init = 8'd255; wren_init = 1'b1; data_init = 8'hAB;
    #1;
    chk("init_address", address, 8'd255);
    chk("init_wren", {7'd0, wren}, 8'd1);
    chk("init_data", data, 8'hAB);
    chk("init_wren_d", {7'd0, wren_d}, 8'd0);
    chk("init_address_d", {3'd0, address_d}, 8'd0);
    chk("init_address_m", {3'd0, address_m}, 8'd0);
    tick();
    mem_sel_init = 2'd2;
    #1;
    chk("init_trunc_address_d", {3'd0, address_d}, 8'd31);
    chk("init_trunc_wren_d", {7'd0, wren_d}, 8'd1);
    chk("init_trunc_data_d", data_d, 8'hAB);
    chk("init_trunc_wren", {7'd0, wren}, 8'd0);
    tick();

    // Shuffle takes over.
    start_init = 1'b0; start_shuffle = 1'b1; mem_sel_shuffle = 2'd1;
    address_shuffle = 8'd255; wren_shuffle = 1'b1; data_shuffle = 8'h3C;
    #1;
    chk("shuf_wren1", {7'd0, wren}, 8'd1);
    chk("shuf_address", address, 8'd255);
    chk("shuf_data", data, 8'h3C);
    chk("shuf_rd", output_data_shuffle, 8'h01);
    tick();
    wren_shuffle = 1'b0;
    #1;
    chk("shuf_wren0", {7'd0, wren}, 8'd0);
    tick();

    // Decrypt: S write, decrypted-RAM write, ROM read.
    start_shuffle = 1'b0; start_decrypt = 1'b1; mem_sel_decrypt = 2'd1;
    address_decrypt = 8'd10; wren_decrypt = 1'b1; data_decrypt = 8'h5A;
    #1;
    chk("dec1_address", address, 8'd10);
    chk("dec1_wren", {7'd0, wren}, 8'd1);
    chk("dec1_data", data, 8'h5A);
    tick();
    mem_sel_decrypt = 2'd2;
    #1;
    chk("dec2_address_d", {3'd0, address_d}, 8'd10);
    chk("dec2_wren_d", {7'd0, wren_d}, 8'd1);
    chk("dec2_data_d", data_d, 8'h5A);
    chk("dec2_wren", {7'd0, wren}, 8'd0);
    tick();
    mem_sel_decrypt = 2'd3;
    #1;
    chk("dec3_address_m", {3'd0, address_m}, 8'd10);
    chk("dec3_wren", {7'd0, wren}, 8'd0);
    chk("dec3_wren_d", {7'd0, wren_d}, 8'd0);
    tick();

    // No owner.
    start_decrypt = 1'b0;
    #1;
    chk_idle_ports("idle");
    tick();
    chk("no_conflict_yet", {7'd0, conflict}, 8'd0);

    // Overlapping starts: init wins, conflict becomes sticky.
    start_init = 1'b1; mem_sel_init = 2'd1; address_init = 8'd7; wren_init = 1'b0;
    start_decrypt = 1'b1; mem_sel_decrypt = 2'd3;
    #1;
    chk("conf_address", address, 8'd7);
    chk("conf_address_m", {3'd0, address_m}, 8'd0);
    chk("conf_pre_edge", {7'd0, conflict}, 8'd0);
    tick();
    chk("conf_set", {7'd0, conflict}, 8'd1);
    start_init = 1'b0;
    tick();
    chk("conf_held", {7'd0, conflict}, 8'd1);

    // Reset mid-decrypt clears the read select and the conflict flag.
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_comb_address_m", {3'd0, address_m}, 8'd10);
    tick();
    chk("rst_conflict", {7'd0, conflict}, 8'd0);
    reset_n = 1'b1;
    start_decrypt = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
